// File: rtl/pkt_splitter.sv
// pkt_splitter: unpacks back-to-back length-headed packets from 32-bit lanes and re-aligns them onto two engines alternately.
// Define SPLIT_ERR_CHK_EN to drop packets whose header exceeds MAX_PKT_BYTES and pulse err.
module pkt_splitter #(
    parameter int DATA_WIDTH    = 255,
    parameter int LENGTH_WIDTH  = 31,
    parameter int MAX_PKT_BYTES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH:0]   DATA_IN,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic [DATA_WIDTH:0]   DATA_OUT1,
    output logic                  valid_1,
    input  logic                  ready_1,
    output logic [DATA_WIDTH:0]   DATA_OUT2,
    output logic                  valid_2,
    input  logic                  ready_2,
    output logic                  err
);
    localparam int RW = LENGTH_WIDTH - 1;

    typedef enum logic [1:0] {FETCH, PARSE, COPY, EMIT} state_t;

    state_t                state;
    logic                  engine;
    logic                  fetch_rdy;
    logic [3:0]            rd_lane, wr_lane;
    logic [RW-1:0]         rem;
    logic [DATA_WIDTH:0]   in_buf, out_buf;

    // Shifting left by rd_lane lanes puts the current read lane in lane 0.
    logic [DATA_WIDTH:0]   shifted, mask, new_out;
    logic [LENGTH_WIDTH:0] hdr;
    logic [RW-1:0]         hdr_lanes, new_rem;
    logic [3:0]            rd_left, wr_left, rem_c, n_io, n, new_rd, new_wr;
    logic                  word_done;

    assign ready_in  = fetch_rdy & ~reset;
    assign shifted   = in_buf << {rd_lane, 5'b0};
    assign hdr       = shifted[DATA_WIDTH -: LENGTH_WIDTH + 1];
    assign hdr_lanes = hdr[LENGTH_WIDTH:2] + RW'(|hdr[1:0]);
    assign rd_left   = 4'd8 - rd_lane;
    assign wr_left   = 4'd8 - wr_lane;
    assign rem_c     = (rem > RW'(8)) ? 4'd8 : rem[3:0];
    assign n_io      = (rd_left < wr_left) ? rd_left : wr_left;
    assign n         = (n_io < rem_c) ? n_io : rem_c;
    assign mask      = ~({(DATA_WIDTH + 1){1'b1}} >> {n, 5'b0}) >> {wr_lane, 5'b0};
    assign new_out   = out_buf | ((shifted >> {wr_lane, 5'b0}) & mask);
    assign new_rd    = rd_lane + n;
    assign new_wr    = wr_lane + n;
    assign new_rem   = rem - RW'(n);
    assign word_done = (new_wr == 4'd8) || (new_rem == '0);

`ifdef SPLIT_ERR_CHK_EN
    logic drop;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            engine    <= 1'b0;
            fetch_rdy <= 1'b0;
            rd_lane   <= 4'd8;
            wr_lane   <= 4'd0;
            rem       <= '0;
            in_buf    <= '0;
            out_buf   <= '0;
            valid_1   <= 1'b0;
            valid_2   <= 1'b0;
            DATA_OUT1 <= '0;
            DATA_OUT2 <= '0;
`ifdef SPLIT_ERR_CHK_EN
            err       <= 1'b0;
            drop      <= 1'b0;
`endif
        end else begin
`ifdef SPLIT_ERR_CHK_EN
            err <= 1'b0;
`endif
            case (state)
                FETCH: begin
                    if (ready_in && valid_in) begin
                        in_buf    <= DATA_IN;
                        rd_lane   <= 4'd0;
                        fetch_rdy <= 1'b0;
                        state     <= (rem != '0) ? COPY : PARSE;
                    end else begin
                        fetch_rdy <= 1'b1;
                    end
                end
                PARSE: begin
                    if (hdr == '0) begin
                        rd_lane   <= 4'd8;
                        fetch_rdy <= 1'b1;
                        state     <= FETCH;
                    end else begin
                        rem     <= hdr_lanes;
                        out_buf <= '0;
                        wr_lane <= 4'd0;
                        state   <= COPY;
`ifdef SPLIT_ERR_CHK_EN
                        if (hdr > (LENGTH_WIDTH + 1)'(MAX_PKT_BYTES)) begin
                            err  <= 1'b1;
                            drop <= 1'b1;
                        end
`endif
                    end
                end
                COPY: begin
                    out_buf <= new_out;
                    rd_lane <= new_rd;
                    wr_lane <= new_wr;
                    rem     <= new_rem;
                    if (!word_done) begin
                        fetch_rdy <= 1'b1;
                        state     <= FETCH;
                    end
`ifdef SPLIT_ERR_CHK_EN
                    // Dropped packets retire their words here instead of visiting EMIT.
                    else if (drop) begin
                        if (new_rem == '0) begin
                            drop <= 1'b0;
                        end else begin
                            out_buf <= '0;
                            wr_lane <= 4'd0;
                        end
                        fetch_rdy <= (new_rd == 4'd8);
                        state     <= (new_rd == 4'd8) ? FETCH : (new_rem == '0) ? PARSE : COPY;
                    end
`endif
                    else begin
                        valid_1 <= ~engine;
                        valid_2 <= engine;
                        if (engine) DATA_OUT2 <= new_out;
                        else DATA_OUT1 <= new_out;
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    if (engine ? ready_2 : ready_1) begin
                        valid_1 <= 1'b0;
                        valid_2 <= 1'b0;
                        if (rem == '0) begin
                            engine <= ~engine;
                        end else begin
                            out_buf <= '0;
                            wr_lane <= 4'd0;
                        end
                        fetch_rdy <= (rd_lane == 4'd8);
                        state     <= (rd_lane == 4'd8) ? FETCH : (rem == '0) ? PARSE : COPY;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_pkt_splitter.sv
// tb_pkt_splitter: directed and randomized checks of pkt_splitter against a lane-stream reference model.
module tb_pkt_splitter;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [255:0] DATA_IN = '0;
    logic         valid_in = 1'b0;
    logic         ready_in;
    logic [255:0] DATA_OUT1, DATA_OUT2;
    logic         valid_1, valid_2;
    logic         ready_1 = 1'b1, ready_2 = 1'b1;
    logic         err;

    int vectors = 0, fails = 0;
    logic [255:0] exp1[$], exp2[$];
    bit   m_engine = 1'b0;
    int   exp_err = 0, err_seen = 0;
    bit   rnd_ready = 1'b0;
    logic f1 = 1'b1, f2 = 1'b1;
    bit   hold1 = 1'b0, hold2 = 1'b0;
    logic [255:0] held1, held2;

    always #5 clk = ~clk;

    pkt_splitter #(.MAX_PKT_BYTES(64)) dut (
        .clk(clk), .reset(reset), .DATA_IN(DATA_IN), .valid_in(valid_in), .ready_in(ready_in),
        .DATA_OUT1(DATA_OUT1), .valid_1(valid_1), .ready_1(ready_1),
        .DATA_OUT2(DATA_OUT2), .valid_2(valid_2), .ready_2(ready_2), .err(err)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Output monitor: drives engine readies, scoreboards transfers, checks hold stability.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            hold1 = 1'b0;
            hold2 = 1'b0;
        end else begin
            if (hold1) begin
                vectors++;
                if (valid_1 !== 1'b1 || DATA_OUT1 !== held1) begin
                    fails++;
                    $display("FAIL hold1: valid=%b data=%h required valid=1 data=%h", valid_1, DATA_OUT1, held1);
                end
            end
            if (hold2) begin
                vectors++;
                if (valid_2 !== 1'b1 || DATA_OUT2 !== held2) begin
                    fails++;
                    $display("FAIL hold2: valid=%b data=%h required valid=1 data=%h", valid_2, DATA_OUT2, held2);
                end
            end
            ready_1 = rnd_ready ? ($urandom_range(3) != 0) : f1;
            ready_2 = rnd_ready ? ($urandom_range(3) != 0) : f2;
            if (valid_1 === 1'b1 && valid_2 === 1'b1) begin
                fails++;
                $display("FAIL both_valid: valid_1=1 valid_2=1 required not both");
            end
            if ((valid_1 === 1'b1 || valid_2 === 1'b1) && ready_in !== 1'b0) begin
                fails++;
                $display("FAIL ready_in_emit: ready_in=%b required 0 while output pending", ready_in);
            end
            if (err === 1'b1) err_seen++;
            if (valid_1 === 1'b1 && ready_1) begin
                vectors++;
                if (exp1.size() == 0) begin
                    fails++;
                    $display("FAIL out1_extra: got %h required no word", DATA_OUT1);
                end else begin
                    if (DATA_OUT1 !== exp1[0]) begin
                        fails++;
                        $display("FAIL out1: got %h required %h", DATA_OUT1, exp1[0]);
                    end
                    void'(exp1.pop_front());
                end
            end
            if (valid_2 === 1'b1 && ready_2) begin
                vectors++;
                if (exp2.size() == 0) begin
                    fails++;
                    $display("FAIL out2_extra: got %h required no word", DATA_OUT2);
                end else begin
                    if (DATA_OUT2 !== exp2[0]) begin
                        fails++;
                        $display("FAIL out2: got %h required %h", DATA_OUT2, exp2[0]);
                    end
                    void'(exp2.pop_front());
                end
            end
            hold1 = (valid_1 === 1'b1) && !ready_1;
            held1 = DATA_OUT1;
            hold2 = (valid_2 === 1'b1) && !ready_2;
            held2 = DATA_OUT2;
        end
    end

    function automatic logic [255:0] pack(input logic [31:0] ln[$], input int w);
        logic [255:0] wd = '0;
        for (int j = 0; j < 8; j++) wd[255 - 32 * j -: 32] = ln[8 * w + j];
        return wd;
    endfunction

    // Reference: walk the lane stream word by word; a zero header discards the rest of its word.
    task automatic model_stream(input logic [31:0] ln[$]);
        int rem = 0;
        bit drop = 1'b0;
        logic [31:0] cur[$];
        logic [31:0] x;
        logic [255:0] wd;
        for (int w = 0; w < ln.size() / 8; w++) begin
            for (int p = 0; p < 8; p++) begin
                x = ln[8 * w + p];
                if (rem == 0) begin
                    if (x == 0) break;
                    rem = int'((longint'(x) + 3) / 4);
                    cur.delete();
                    drop = 1'b0;
`ifdef SPLIT_ERR_CHK_EN
                    drop = x > 64;
`endif
                end
                cur.push_back(x);
                rem--;
                if (rem == 0) begin
                    if (drop) exp_err++;
                    else begin
                        for (int i = 0; i < cur.size(); i += 8) begin
                            wd = '0;
                            for (int j = 0; j < 8 && i + j < cur.size(); j++) wd[255 - 32 * j -: 32] = cur[i + j];
                            if (m_engine) exp2.push_back(wd);
                            else exp1.push_back(wd);
                        end
                        m_engine = ~m_engine;
                    end
                end
            end
        end
    endtask

    task automatic send(input logic [31:0] ln[$]);
        int t;
        for (int w = 0; w < ln.size() / 8; w++) begin
            if (rnd_ready) repeat ($urandom_range(2)) @(negedge clk);
            DATA_IN = pack(ln, w);
            valid_in = 1'b1;
            t = 0;
            while (ready_in !== 1'b1 && t < 3000) begin
                @(negedge clk);
                t++;
            end
            if (ready_in !== 1'b1) begin
                fails++;
                $display("FAIL accept_timeout: ready_in=%b required 1 within 3000 cycles", ready_in);
                valid_in = 1'b0;
                return;
            end
            @(negedge clk);
            valid_in = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp1.size() != 0 || exp2.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (exp1.size() != 0 || exp2.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: pending e1=%0d e2=%0d required 0", exp1.size(), exp2.size());
            exp1.delete();
            exp2.delete();
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (err_seen != exp_err) begin
            fails++;
            $display("FAIL err_count: got %0d pulse cycles required %0d", err_seen, exp_err);
        end
    endtask

    task automatic run(input logic [31:0] ln[$]);
        model_stream(ln);
        send(ln);
        drain();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (ready_in !== 1'b0 || valid_1 !== 1'b0 || valid_2 !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: ready_in=%b v1=%b v2=%b err=%b required 0000", ready_in, valid_1, valid_2, err);
        end
        reset = 1'b0;
        exp1.delete();
        exp2.delete();
        m_engine = 1'b0;
        exp_err = 0;
        err_seen = 0;
        @(negedge clk);
        vectors++;
        if (ready_in !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_reset: got %b required 1", ready_in);
        end
    endtask

    task automatic test_reset();
        rnd_ready = 1'b0; f1 = 1'b1; f2 = 1'b1;
        do_reset();
        vectors++;
        if (DATA_OUT1 !== '0 || DATA_OUT2 !== '0) begin
            fails++;
            $display("FAIL reset_data: d1=%h d2=%h required 0", DATA_OUT1, DATA_OUT2);
        end
    endtask

    task automatic test_single();
        logic [31:0] ln[$] = '{32'h8, 32'hAAAA0001, 0, 0, 0, 0, 0, 0};
        do_reset();
        model_stream(ln);
        DATA_IN = pack(ln, 0);
        valid_in = 1'b1;
        vectors++;
        if (ready_in !== 1'b1) begin
            fails++;
            $display("FAIL single_ready: got %b required 1", ready_in);
        end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            valid_in = 1'b0;
            vectors++;
            if (valid_1 !== (c == 3) || valid_2 !== 1'b0) begin
                fails++;
                $display("FAIL latency_c%0d: v1=%b v2=%b required v1=%b v2=0", c, valid_1, valid_2, c == 3);
            end
        end
        drain();
    endtask

    task automatic test_span();
        logic [31:0] ln[$] = '{32'hC, 32'h11, 32'h22, 32'h18, 32'h33, 32'h44, 32'h55, 32'h66,
                               32'hBEEF0005, 0, 0, 0, 0, 0, 0, 0};
        do_reset();
        run(ln);
    endtask

    task automatic test_long();
        logic [31:0] ln[$];
        do_reset();
        ln.push_back(32'h28);
        repeat (9) ln.push_back($urandom);
        ln.push_back(32'h4);
        ln.push_back(0);
        while (ln.size() % 8 != 0) ln.push_back(0);
        run(ln);
    endtask

    task automatic test_backpressure();
        logic [31:0] ln[$] = '{32'h10, 32'hA1, 32'hA2, 32'hA3, 0, 0, 0, 0};
        logic [255:0] first;
        int t = 0;
        do_reset();
        f1 = 1'b0;
        model_stream(ln);
        send(ln);
        while (valid_1 !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        first = DATA_OUT1;
        for (int c = 0; c < 10; c++) begin
            vectors++;
            if (valid_1 !== 1'b1 || DATA_OUT1 !== exp1[0] || DATA_OUT1 !== first || ready_in !== 1'b0 || valid_2 !== 1'b0) begin
                fails++;
                $display("FAIL backpressure_c%0d: v1=%b d1=%h rdy=%b v2=%b required v1=1 d1=%h rdy=0 v2=0",
                         c, valid_1, DATA_OUT1, ready_in, valid_2, exp1[0]);
            end
            @(negedge clk);
        end
        f1 = 1'b1;
        drain();
    endtask

    task automatic test_reset_mid();
        logic [31:0] a[$] = '{32'h4, 32'h28, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
        logic [31:0] b[$] = '{32'h8, 32'hC0FFEE, 0, 0, 0, 0, 0, 0};
        do_reset();
        run(a);
        do_reset();
        run(b);
    endtask

`ifdef SPLIT_ERR_CHK_EN
    task automatic test_drop();
        logic [31:0] ln[$];
        do_reset();
        ln.push_back(32'h100);
        repeat (63) ln.push_back($urandom);
        ln.push_back(32'h8);
        ln.push_back(32'h5A5A);
        while (ln.size() % 8 != 0) ln.push_back(0);
        run(ln);
    endtask
`endif

    task automatic test_random();
        logic [31:0] ln[$];
        int len;
        do_reset();
        rnd_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            ln.delete();
            for (int k = 0; k < 40; k++) begin
                len = $urandom_range(80, 1);
                ln.push_back(32'(len));
                repeat ((len + 3) / 4 - 1) ln.push_back($urandom);
                if ($urandom_range(4) == 0) begin
                    ln.push_back(0);
                    while (ln.size() % 8 != 0) ln.push_back(0);
                end
            end
            while (ln.size() % 8 != 0) ln.push_back(0);
            run(ln);
        end
        rnd_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_span();
        test_long();
        test_backpressure();
        test_reset_mid();
`ifdef SPLIT_ERR_CHK_EN
        test_drop();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
